regmux_skid: RTL

REGMUX_SKID -- requirements
Module: regmux_skid

---
 rtl/regmux_skid.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regmux_skid.sv
// regmux_skid: selects one lane out of NUM_IN flattened input lanes and passes
// the selected beat through a two-entry buffer (output register OUT plus
// skid register SKID). Latency is one cycle, and the block sustains one beat
// per cycle while the output is ready.
//
// Ports:
//   clk       - single clock; all state updates happen on the rising edge
//   reset_n   - synchronous active-low reset
//   in_data   - NUM_IN*WIDTH flattened lanes; lane k = in_data[k*WIDTH +: WIDTH]
//   in_sel    - lane select
//   in_valid  - upstream beat present
//   in_ready  - block can accept a beat (registered)
//   out_data  - selected data (registered)
//   out_valid - out_data holds a beat
//   out_ready - downstream accepts
//   flush     - discard all held beats
//   sel_err   - sticky flag, set when a beat is accepted with in_sel >= NUM_IN
//
// Handshake: a beat moves across an interface on any rising edge where both
// valid and ready are 1. Once valid is raised, the source holds the beat
// stable until that edge. in_ready is a register and never follows
// out_ready combinationally.
module regmux_skid #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  logic             sel_ok;
  logic [WIDTH-1:0] sel_val;
  logic             accept;
  logic             out_free;

  logic [WIDTH-1:0] n_out_data;
  logic             n_out_valid;
  logic [WIDTH-1:0] n_skid_data;
  logic             n_skid_valid;
  logic             n_in_ready;
  logic             n_sel_err;

  // Lane mux. An out-of-range select matches no lane and yields all zeros.
  always_comb begin
    sel_ok  = 1'b0;
    sel_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_ok  = 1'b1;
        sel_val = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept   = in_valid & in_ready;
  // OUT can take a new value when it is empty or is being drained this cycle.
  assign out_free = ~out_valid | out_ready;

  always_comb begin
    n_out_data   = out_data;
    n_out_valid  = out_valid;
    n_skid_data  = skid_data;
    n_skid_valid = skid_valid;

    if (out_free) begin
      if (skid_valid) begin
        // The older beat in SKID moves up first. Any new beat takes its place.
        n_out_data   = skid_data;
        n_out_valid  = 1'b1;
        n_skid_valid = accept;
        if (accept) begin
          n_skid_data = sel_val;
        end
      end else if (accept) begin
        n_out_data  = sel_val;
        n_out_valid = 1'b1;
      end else begin
        // OUT is drained (or was already empty). out_data keeps its value.
        n_out_valid = 1'b0;
      end
    end else if (accept) begin
      // OUT is stalled. in_ready=1 guarantees that SKID is empty here.
      n_skid_data  = sel_val;
      n_skid_valid = 1'b1;
    end

    // A flush drops everything held, including a beat accepted this cycle.
    // A transfer in the same cycle has already completed downstream.
    if (flush) begin
      n_out_valid  = 1'b0;
      n_skid_valid = 1'b0;
    end

    n_in_ready = ~n_skid_valid;
    // The bad select is recorded even if a flush drops the beat.
    n_sel_err  = sel_err | (accept & ~sel_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      sel_err    <= 1'b0;
    end else begin
      out_data   <= n_out_data;
      out_valid  <= n_out_valid;
      skid_data  <= n_skid_data;
      skid_valid <= n_skid_valid;
      in_ready   <= n_in_ready;
      sel_err    <= n_sel_err;
    end
  end

endmodule
